// File: rtl/audio_pkg.sv
// Shared audio constants and types for the board audio output path.
package audio_pkg;
   localparam int unsigned AUDIO_DW        = 16;
   localparam int unsigned AUDIO_RATE_DFLT = 48000;
   localparam int unsigned SLOT_BITS_DFLT  = 32;
   localparam int unsigned FRAME_BITS      = 2 * SLOT_BITS_DFLT;

   typedef logic [AUDIO_DW-1:0] sample_t;
endpackage

// File: rtl/audio_frac_ce.sv
// Fractional-accumulator clock enable: pulses ce at an average rate of (STEP << rate_shift) / CLK_RATE per clk.
module audio_frac_ce #(
   parameter int unsigned CLK_RATE = 24576000,
   parameter int unsigned STEP     = 6144000
) (
   input  logic clk,
   input  logic reset,
   input  logic rate_shift,
   output logic ce
);
   logic [31:0] acc_q;
   logic [31:0] acc_d;
   logic [31:0] sum;

   // acc stays below CLK_RATE and the step never exceeds CLK_RATE, so 32 bits cannot overflow.
   always_comb begin
      sum   = acc_q + (32'(STEP) << rate_shift);
      ce    = (sum >= 32'(CLK_RATE));
      acc_d = ce ? (sum - 32'(CLK_RATE)) : sum;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end
endmodule

// File: rtl/audio_i2s_tx.sv
// I2S transmitter: holds one stereo sample from the mixer and serialises it MSB-first, one BCLK after each LRCLK change.
module audio_i2s_tx
   import audio_pkg::*;
#(
   parameter int unsigned CLK_RATE   = 24576000,
   parameter int unsigned AUDIO_RATE = AUDIO_RATE_DFLT,
   parameter int unsigned SLOT_BITS  = SLOT_BITS_DFLT
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       sample_rate,
   input  logic signed [AUDIO_DW-1:0] in_l,
   input  logic signed [AUDIO_DW-1:0] in_r,
   input  logic                       in_valid,
   output logic                       i2s_bclk,
   output logic                       i2s_lrclk,
   output logic                       i2s_sdata,
   output logic                       frame_start,
   output logic                       underrun,
   output logic                       overrun
);
   localparam int unsigned NBITS = 2 * SLOT_BITS;
   localparam int unsigned BW    = $clog2(NBITS);
   localparam int unsigned STEP  = 2 * AUDIO_RATE * 2 * SLOT_BITS;

   localparam logic [BW-1:0] B_LAST  = BW'(NBITS - 1);
   localparam logic [BW-1:0] B_SLOT  = BW'(SLOT_BITS);
   localparam logic [BW-1:0] L_FIRST = BW'(1);
   localparam logic [BW-1:0] L_LAST  = BW'(AUDIO_DW);
   localparam logic [BW-1:0] R_FIRST = BW'(SLOT_BITS + 1);
   localparam logic [BW-1:0] R_LAST  = BW'(SLOT_BITS + AUDIO_DW);

   logic          ce;
   logic          fall;
   logic          load;
   logic [BW-1:0] b_inc;

   logic          bclk_q, bclk_d;
   logic [BW-1:0] b_q, b_d;
   logic          lrclk_q, lrclk_d;
   logic          sdata_q, sdata_d;
   logic          frame_start_q, frame_start_d;
   logic          underrun_q, underrun_d;
   logic          overrun_q, overrun_d;
   logic          sr_q, sr_d;
   logic          hold_full_q, hold_full_d;
   sample_t       hold_l_q, hold_l_d;
   sample_t       hold_r_q, hold_r_d;
   sample_t       l_q, l_d;
   sample_t       r_q, r_d;
   sample_t       sh_l_q, sh_l_d;
   sample_t       sh_r_q, sh_r_d;

   audio_frac_ce #(
      .CLK_RATE (CLK_RATE),
      .STEP     (STEP)
   ) u_bclk_ce (
      .clk        (clk),
      .reset      (reset),
      .rate_shift (sr_q),
      .ce         (ce)
   );

   always_comb begin
      fall  = ce & bclk_q;
      b_inc = (b_q == B_LAST) ? '0 : b_q + BW'(1);
      load  = fall & (b_inc == '0);

      bclk_d        = bclk_q;
      b_d           = b_q;
      lrclk_d       = lrclk_q;
      sdata_d       = sdata_q;
      frame_start_d = 1'b0;
      underrun_d    = 1'b0;
      overrun_d     = 1'b0;
      sr_d          = sr_q;
      hold_full_d   = hold_full_q;
      hold_l_d      = hold_l_q;
      hold_r_d      = hold_r_q;
      l_d           = l_q;
      r_d           = r_q;
      sh_l_d        = sh_l_q;
      sh_r_d        = sh_r_q;

      if (ce) begin
         bclk_d = ~bclk_q;
      end

      if (fall) begin
         b_d     = b_inc;
         lrclk_d = (b_inc >= B_SLOT);
         sdata_d = 1'b0;
         if (b_inc >= L_FIRST && b_inc <= L_LAST) begin
            sdata_d = sh_l_q[AUDIO_DW-1];
            sh_l_d  = sh_l_q << 1;
         end else if (b_inc >= R_FIRST && b_inc <= R_LAST) begin
            sdata_d = sh_r_q[AUDIO_DW-1];
            sh_r_d  = sh_r_q << 1;
         end
      end

      // An empty hold at load time replays the previous sample rather than sending silence.
      if (load) begin
         frame_start_d = 1'b1;
         sr_d          = sample_rate;
         if (hold_full_q) begin
            l_d         = hold_l_q;
            r_d         = hold_r_q;
            sh_l_d      = hold_l_q;
            sh_r_d      = hold_r_q;
            hold_full_d = 1'b0;
         end else begin
            sh_l_d     = l_q;
            sh_r_d     = r_q;
            underrun_d = 1'b1;
         end
      end

      // Applied after the load so a coincident strobe refills the hold the load just drained.
      if (in_valid) begin
         hold_l_d    = in_l;
         hold_r_d    = in_r;
         hold_full_d = 1'b1;
         overrun_d   = hold_full_q & ~load;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bclk_q        <= 1'b0;
         b_q           <= B_LAST;
         lrclk_q       <= 1'b0;
         sdata_q       <= 1'b0;
         frame_start_q <= 1'b0;
         underrun_q    <= 1'b0;
         overrun_q     <= 1'b0;
         sr_q          <= 1'b0;
         hold_full_q   <= 1'b0;
         hold_l_q      <= '0;
         hold_r_q      <= '0;
         l_q           <= '0;
         r_q           <= '0;
         sh_l_q        <= '0;
         sh_r_q        <= '0;
      end else begin
         bclk_q        <= bclk_d;
         b_q           <= b_d;
         lrclk_q       <= lrclk_d;
         sdata_q       <= sdata_d;
         frame_start_q <= frame_start_d;
         underrun_q    <= underrun_d;
         overrun_q     <= overrun_d;
         sr_q          <= sr_d;
         hold_full_q   <= hold_full_d;
         hold_l_q      <= hold_l_d;
         hold_r_q      <= hold_r_d;
         l_q           <= l_d;
         r_q           <= r_d;
         sh_l_q        <= sh_l_d;
         sh_r_q        <= sh_r_d;
      end
   end

   assign i2s_bclk    = bclk_q;
   assign i2s_lrclk   = lrclk_q;
   assign i2s_sdata   = sdata_q;
   assign frame_start = frame_start_q;
   assign underrun    = underrun_q;
   assign overrun     = overrun_q;
endmodule

// File: tb/tb_audio_i2s_tx.sv
// Randomised bench for audio_i2s_tx: a frame-level timing/sample model predicts every output on every clk.
module tb_audio_i2s_tx;
   localparam int unsigned CLK_RATE   = 24576000;
   localparam int unsigned AUDIO_RATE = 48000;
   localparam int unsigned SLOT_BITS  = 32;
   localparam int unsigned NBITS      = 2 * SLOT_BITS;
   localparam int unsigned STEP0      = 2 * AUDIO_RATE * 2 * SLOT_BITS;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        sample_rate = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] in_l = '0;
   logic [15:0] in_r = '0;
   logic        i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, underrun, overrun;
   wire  [5:0]  outs = {i2s_bclk, i2s_lrclk, i2s_sdata, frame_start, underrun, overrun};

   int checks = 0;
   int failures = 0;

   // model state: owned by the monitor, read by the stimulus
   int          k, fs_cyc, next_fs, half;
   bit          m_full;
   logic [15:0] m_hl, m_hr, m_l, m_r;
   // observed DUT events
   int          obs_ur, obs_or, obs_fs_prev, obs_fs_len;
   logic [63:0] cap, last_frame;
   logic        prev_bclk;

   always #5 clk = ~clk;

   audio_i2s_tx dut (
      .clk         (clk),
      .reset       (reset),
      .sample_rate (sample_rate),
      .in_l        (in_l),
      .in_r        (in_r),
      .in_valid    (in_valid),
      .i2s_bclk    (i2s_bclk),
      .i2s_lrclk   (i2s_lrclk),
      .i2s_sdata   (i2s_sdata),
      .frame_start (frame_start),
      .underrun    (underrun),
      .overrun     (overrun)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int half_for(input logic sr);
      return int'(CLK_RATE / (STEP0 << sr));
   endfunction

   function automatic logic [63:0] exp_frame(input logic [15:0] l, input logic [15:0] r);
      return {1'b0, l, 15'b0, 1'b0, r, 15'b0};
   endfunction

   // Per-clk reference: frame position follows from frame-start cycle and BCLK half period.
   always @(posedge clk) begin
      bit fs, ur, ov, full0, e_bclk, e_lr, e_sd;
      int t, b;
      if (reset) begin
         k = 0; fs_cyc = 0; half = half_for(1'b0); next_fs = 2 * half;
         m_full = 0; m_hl = '0; m_hr = '0; m_l = '0; m_r = '0;
         obs_fs_prev = 0; cap = '0; prev_bclk = 1'b0;
      end else begin
         k++;
         fs = (k == next_fs);
         full0 = m_full;
         ur = 0;
         if (fs) begin
            fs_cyc = k;
            half = half_for(sample_rate);
            next_fs = k + 2 * half * int'(NBITS);
            if (full0) begin
               m_l = m_hl; m_r = m_hr; m_full = 0;
            end else begin
               ur = 1;
            end
         end
         ov = in_valid && full0 && !fs;
         if (in_valid) begin
            m_hl = in_l; m_hr = in_r; m_full = 1;
         end
         t = k - fs_cyc;
         b = t / (2 * half);
         e_bclk = (t % (2 * half)) >= half;
         e_lr = (b >= int'(SLOT_BITS));
         e_sd = 0;
         if (b >= 1 && b <= 16) e_sd = m_l[16 - b];
         else if (b >= 33 && b <= 48) e_sd = m_r[48 - b];
         #1;
         chk("outs{bclk,lr,sd,fs,ur,ov}", 64'(outs), 64'({e_bclk, e_lr, e_sd, fs, ur, ov}));
         if (frame_start) begin
            obs_fs_len = k - obs_fs_prev;
            obs_fs_prev = k;
            last_frame = cap;
         end
         if (underrun) obs_ur++;
         if (overrun) obs_or++;
         if (!prev_bclk && i2s_bclk) cap = {cap[62:0], i2s_sdata};
         prev_bclk = i2s_bclk;
      end
   end

   task automatic send(input logic [15:0] l, input logic [15:0] r);
      in_valid = 1'b1; in_l = l; in_r = r;
      @(negedge clk);
      in_valid = 1'b0;
      $display("send L=%h R=%h at k=%0d", l, r, k);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_fs();
      int target = next_fs;
      int n = 0;
      while (k < target && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (k < target) chk("wait_fs_timeout", 64'(k), 64'(target));
   endtask

   task automatic wait_pre_fs();
      int n = 0;
      while (k + 1 != next_fs && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (k + 1 != next_fs) chk("wait_pre_fs_timeout", 64'(k + 1), 64'(next_fs));
   endtask

   initial begin
      int ur0, or0, n;
      idle(3);
      chk("reset_outs", 64'(outs), 64'(0));
      reset = 1'b0;

      // Scenario 1: first sample rides the first frame
      idle(2);
      send(16'h8001, 16'h7FFE);
      wait_fs(); wait_fs();
      chk("frame1_data", last_frame, exp_frame(16'h8001, 16'h7FFE));
      chk("frame1_len", 64'(obs_fs_len), 64'(512));

      // Scenario 2: no new samples -> one underrun per frame, sample repeated
      ur0 = obs_ur;
      wait_fs(); wait_fs(); wait_fs();
      chk("underrun_count", 64'(obs_ur - ur0), 64'(3));
      chk("repeat_data", last_frame, exp_frame(16'h8001, 16'h7FFE));

      // Scenario 3: two samples in one frame -> overrun, newer wins
      or0 = obs_or;
      idle(100);
      send(16'h1234, 16'h5678);
      idle(50);
      send(16'hABCD, 16'hEF01);
      chk("overrun_count", 64'(obs_or - or0), 64'(1));
      wait_fs(); wait_fs();
      chk("overrun_data", last_frame, exp_frame(16'hABCD, 16'hEF01));

      // Scenario 5: strobe on the load clk with hold full
      idle(30);
      send(16'h1111, 16'h2222);
      or0 = obs_or; ur0 = obs_ur;
      wait_pre_fs();
      send(16'h3333, 16'h4444);
      chk("coincident_no_overrun", 64'(obs_or - or0), 64'(0));
      wait_fs();
      chk("coincident_old_data", last_frame, exp_frame(16'h1111, 16'h2222));
      chk("coincident_no_underrun", 64'(obs_ur - ur0), 64'(0));
      wait_fs();
      chk("coincident_new_data", last_frame, exp_frame(16'h3333, 16'h4444));

      // Random samples at random spacing
      for (int i = 0; i < 12; i++) begin
         idle($urandom_range(20, 700));
         send(16'($urandom), 16'($urandom));
      end

      // Scenario 4: double rate takes effect at the next frame start
      wait_fs();
      idle(200);
      sample_rate = 1'b1;
      wait_fs();
      chk("len_before_sr", 64'(obs_fs_len), 64'(512));
      wait_fs();
      chk("len_after_sr", 64'(obs_fs_len), 64'(256));
      for (int i = 0; i < 6; i++) begin
         idle($urandom_range(10, 350));
         send(16'($urandom), 16'($urandom));
      end
      wait_fs();
      idle(60);
      sample_rate = 1'b0;
      wait_fs();
      chk("len_last_fast", 64'(obs_fs_len), 64'(256));
      wait_fs();
      chk("len_back_slow", 64'(obs_fs_len), 64'(512));

      // Scenario 6: reset inside the right slot
      send(16'h5A5A, 16'hA5A5);
      wait_fs();
      n = 0;
      while ((k - fs_cyc) / (2 * half) < 40 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      reset = 1'b1;
      #1;
      chk("midframe_reset_outs", 64'(outs), 64'(0));
      idle(3);
      reset = 1'b0;
      ur0 = obs_ur;
      wait_fs();
      chk("post_reset_underrun", 64'(obs_ur - ur0), 64'(1));
      idle(40);
      send(16'hC3C3, 16'h3C3C);
      wait_fs(); wait_fs();
      chk("post_reset_data", last_frame, exp_frame(16'hC3C3, 16'h3C3C));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
